op_dispatcher: RTL and testbench
================================

OP_DISPATCHER -- requirements
Module: op_dispatcher

Interface
REQ-001 Parameter WORD_LENGHT, default 4, sets the operand width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 2*WORD_LENGHT+10+WORD_LENGHT/2, sets the maximum number of RUN cycles before an abort.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  command request is present.
REQ-006 req_ready  out  1  dispatcher can accept a command.
REQ-007 req_opc  in  2  requested operation: 00 divide, 01 sqrt, 10 multiply, 11 illegal.
REQ-008 req_a, req_b  in  WORD_LENGHT each  operands.
REQ-009 start  out  1  one-cycle load pulse to the control unit.
REQ-010 sync_rst  out  1  forces the control unit to its idle address; only valid together with start.
REQ-011 opc_code  out  2  latched opcode presented to the control unit.
REQ-012 operand_a, operand_b  out  WORD_LENGHT each  latched operands presented to the datapath.
REQ-013 op_done  in  1  datapath/control stop indication.
REQ-014 result_in  in  2*WORD_LENGHT  datapath result.
REQ-015 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-016 rsp_result  out  2*WORD_LENGHT  latched result.
REQ-017 rsp_error  out  1  set on an illegal opcode or a timeout.
REQ-018 busy  out  1  asserted whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, LAUNCH, RUN, ABORT and RESP.
REQ-020 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 On req_valid&req_ready, the block SHALL latch req_opc, req_a and req_b into opc_code, operand_a and operand_b.
- With a legal opcode, the next state SHALL be LAUNCH.
- With opcode 11, the next state SHALL be RESP, with rsp_error=1 and rsp_result=0.
REQ-022 LAUNCH SHALL last exactly one cycle, with start=1 and sync_rst=0, and SHALL always go to RUN.
- op_done sampled in LAUNCH SHALL be ignored.
REQ-023 In RUN, a sampled op_done=1 SHALL capture result_in into rsp_result on the same edge and move to RESP with rsp_error=0.
- The minimum latency from the accept edge to rsp_valid SHALL be 3 cycles.
REQ-024 opc_code, operand_a and operand_b SHALL hold their values from accept until the next accept.
REQ-025 In RESP, rsp_valid SHALL be 1, with rsp_result and rsp_error stable.
- On rsp_ready=1, the next state SHALL be IDLE.
- rsp_valid SHALL NOT drop without a handshake.
REQ-026 A new request SHALL NOT be accepted in the cycle its RESP handshake completes; it is accepted at the earliest one cycle later, in IDLE.
REQ-027 start SHALL be 1 only in LAUNCH and ABORT.
- sync_rst SHALL be 1 only in ABORT.
REQ-028 op_done SHALL be ignored in IDLE, ABORT and RESP.

Reset
REQ-029 While rst=0, the state SHALL be IDLE and the following SHALL be 0: start, sync_rst, opc_code, operand_a, operand_b, rsp_valid, rsp_result, rsp_error, busy and the timeout count.
- req_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no response and no start pulse.

Configuration
REQ-031 With DISPATCH_TIMEOUT_EN defined:
- A cycle counter SHALL clear on entry to RUN and increment each RUN cycle.
- If it reaches TIMEOUT_CYCLES-1 without op_done, the next state SHALL be ABORT.
- ABORT SHALL last one cycle with start=1 and sync_rst=1, then go to RESP with rsp_error=1 and rsp_result=0.
- op_done in the final counted cycle SHALL win over the timeout.
REQ-032 Without DISPATCH_TIMEOUT_EN, no counter SHALL exist, ABORT SHALL be unreachable, and RUN SHALL wait indefinitely for op_done.

Structure
REQ-033 The Definitions package SHALL hold:
- typedef enum dispatch_state_t;
- the opcode constants OPC_DIV, OPC_SQRT, OPC_MUL and OPC_ILLEGAL;
- the shared CeilLog2 function.
REQ-034 The timeout counter SHALL be one instance of the existing CounterWithLoad, sized CeilLog2(TIMEOUT_CYCLES+1); there SHALL be no other sub-modules.

Verification
REQ-035 Multiply: opc=10, a=4'hB, b=4'h3; op_done pulsed 9 cycles after start; result_in=8'h21 -> exactly one start pulse with opc_code=10, then rsp_valid with rsp_result=8'h21 and rsp_error=0.
REQ-036 Illegal opcode: opc=11 -> no start pulse; rsp_valid 1 cycle after accept with rsp_error=1 and rsp_result=0.
REQ-037 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_result stable and req_ready=0 throughout; IDLE and req_ready=1 one cycle after the handshake.
REQ-038 Timeout (DISPATCH_TIMEOUT_EN, WORD_LENGHT=4): op_done never asserted -> ABORT after 20 RUN cycles with start=1 and sync_rst=1 for one cycle, then rsp_error=1. Repeat with op_done arriving in RUN cycle 20 -> normal response.
REQ-039 Reset at RUN cycle 3 -> all outputs at reset values immediately; no rsp_valid; the next request is dispatched normally.
REQ-040 op_done held 1 through LAUNCH -> ignored in LAUNCH; the result is captured in the first RUN cycle.

Source files
------------

// File: rtl/op_dispatcher_pkg.sv
// op_dispatcher shared definitions: FSM state type,
// opcode constants and the CeilLog2 sizing helper.
package op_dispatcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_ABORT  = 3'd3,
    S_RESP   = 3'd4
  } dispatch_state_t;

  localparam logic [1:0] OPC_DIV     = 2'b00;
  localparam logic [1:0] OPC_SQRT    = 2'b01;
  localparam logic [1:0] OPC_MUL     = 2'b10;
  localparam logic [1:0] OPC_ILLEGAL = 2'b11;

  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/op_dispatcher_counter.sv
// CounterWithLoad: loadable up-counter for the RUN timeout.
// Only built when DISPATCH_TIMEOUT_EN is defined.
`ifdef DISPATCH_TIMEOUT_EN
module CounterWithLoad #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/op_dispatcher.sv
// op_dispatcher: accepts opcode/operand commands and drives a control unit.
// DISPATCH_TIMEOUT_EN enables the RUN timeout and ABORT path.
module op_dispatcher
  import op_dispatcher_pkg::*;
#(
  parameter int WORD_LENGHT    = 4,
  parameter int TIMEOUT_CYCLES = 2*WORD_LENGHT+10+WORD_LENGHT/2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_opc,
  input  logic [WORD_LENGHT-1:0]   req_a,
  input  logic [WORD_LENGHT-1:0]   req_b,
  output logic                     start,
  output logic                     sync_rst,
  output logic [1:0]               opc_code,
  output logic [WORD_LENGHT-1:0]   operand_a,
  output logic [WORD_LENGHT-1:0]   operand_b,
  input  logic                     op_done,
  input  logic [2*WORD_LENGHT-1:0] result_in,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*WORD_LENGHT-1:0] rsp_result,
  output logic                     rsp_error,
  output logic                     busy
);

  dispatch_state_t r_state;
  dispatch_state_t w_next;
  logic            w_accept;
  logic            w_illegal;
  logic            w_done;
  logic            w_timeout;

  assign req_ready = (r_state == S_IDLE);
  assign start     = (r_state == S_LAUNCH) || (r_state == S_ABORT);
  assign sync_rst  = (r_state == S_ABORT);
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);

  assign w_accept  = req_valid && req_ready;
  assign w_illegal = (req_opc == OPC_ILLEGAL);
  assign w_done    = (r_state == S_RUN) && op_done;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int CW = CeilLog2(TIMEOUT_CYCLES+1);

  logic [CW-1:0] w_count;
  logic          w_cnt_load;
  logic          w_cnt_en;

  assign w_cnt_load = (r_state == S_LAUNCH);
  assign w_cnt_en   = (r_state == S_RUN);

  CounterWithLoad #(.WIDTH(CW)) u_tmo (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_cnt_load),
    .i_load_val ({CW{1'b0}}),
    .i_en       (w_cnt_en),
    .o_count    (w_count)
  );

  assign w_timeout = (w_count == CW'(TIMEOUT_CYCLES-1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opc_code   <= '0;
      operand_a  <= '0;
      operand_b  <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        opc_code  <= req_opc;
        operand_a <= req_a;
        operand_b <= req_b;
      end
      if (w_accept && w_illegal) begin
        rsp_result <= '0;
        rsp_error  <= 1'b1;
      end else if (w_done) begin
        rsp_result <= result_in;
        rsp_error  <= 1'b0;
      end else if (r_state == S_ABORT) begin
        rsp_result <= '0;
        rsp_error  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          unique case (req_opc)
            OPC_DIV,
            OPC_SQRT,
            OPC_MUL:     w_next = S_LAUNCH;
            OPC_ILLEGAL: w_next = S_RESP;
            default:     w_next = S_IDLE;
          endcase
        end
      end
      S_LAUNCH: w_next = S_RUN;
      S_RUN: begin
        // op_done beats a timeout in the same cycle
        if (op_done)        w_next = S_RESP;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_ABORT: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed testbench for op_dispatcher (WORD_LENGHT=4).
// Timeout scenario adapts to DISPATCH_TIMEOUT_EN.
module tb_op_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_opc = 2'b00;
  logic [3:0] req_a = 4'h0;
  logic [3:0] req_b = 4'h0;
  logic       start;
  logic       sync_rst;
  logic [1:0] opc_code;
  logic [3:0] operand_a;
  logic [3:0] operand_b;
  logic       op_done = 1'b0;
  logic [7:0] result_in = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_error;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int base;

  op_dispatcher #(.WORD_LENGHT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opc    (req_opc),
    .req_a      (req_a),
    .req_b      (req_b),
    .start      (start),
    .sync_rst   (sync_rst),
    .opc_code   (opc_code),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .op_done    (op_done),
    .result_in  (result_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start) n_start <= n_start + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (2) step();
    check("rst_ready", 32'(req_ready), 1);
    check("rst_start", 32'({start, sync_rst}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rspv", 32'(rsp_valid), 0);
    check("rst_rsp", 32'({rsp_error, rsp_result}), 0);
    check("rst_lat", 32'({opc_code, operand_a, operand_b}), 0);
    rst = 1'b1;
    step();

    // multiply, op_done 9 cycles after start
    base = n_start;
    req_valid = 1'b1; req_opc = 2'b10; req_a = 4'hB; req_b = 4'h3;
    step();
    req_valid = 1'b0;
    check("mul_start", 32'({start, sync_rst}), 32'b10);
    check("mul_opc", 32'(opc_code), 2);
    check("mul_ops", 32'({operand_a, operand_b}), 32'hB3);
    check("mul_ready", 32'(req_ready), 0);
    check("mul_busy", 32'(busy), 1);
    repeat (8) step();
    check("mul_nrsp", 32'(rsp_valid), 0);
    op_done = 1'b1; result_in = 8'h21;
    step();
    op_done = 1'b0;
    check("mul_rspv", 32'(rsp_valid), 1);
    check("mul_res", 32'(rsp_result), 32'h21);
    check("mul_err", 32'(rsp_error), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("mul_idle", 32'({req_ready, busy, rsp_valid}), 32'b100);
    check("mul_nstart", 32'(n_start - base), 1);

    // illegal opcode, then a request held during the handshake
    base = n_start;
    req_valid = 1'b1; req_opc = 2'b11; req_a = 4'h1; req_b = 4'h2;
    step();
    check("ill_rspv", 32'(rsp_valid), 1);
    check("ill_err", 32'(rsp_error), 1);
    check("ill_res", 32'(rsp_result), 0);
    check("ill_start", 32'(start), 0);
    req_opc = 2'b00; req_a = 4'h6; req_b = 4'h2;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("hs_noacc", 32'({req_ready, busy}), 32'b10);
    check("hs_hold", 32'({opc_code, operand_a}), 32'h31);
    check("ill_nstart", 32'(n_start - base), 0);

    // op_done held through IDLE/LAUNCH, then backpressure
    op_done = 1'b1; result_in = 8'h5A;
    step();
    req_valid = 1'b0;
    check("div_start", 32'(start), 1);
    check("div_lat", 32'({opc_code, operand_a, operand_b}), 32'h062);
    step();
    check("div_run", 32'({rsp_valid, busy}), 32'b01);
    step();
    check("div_rspv", 32'(rsp_valid), 1);
    check("div_res", 32'({rsp_error, rsp_result}), 32'h05A);
    result_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_res", 32'(rsp_result), 32'h5A);
      check("bp_ready", 32'(req_ready), 0);
      step();
    end
    op_done = 1'b0;
    check("bp_last", 32'({rsp_valid, rsp_result}), 32'h15A);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_idle", 32'({req_ready, busy, rsp_valid}), 32'b100);

    // reset in RUN cycle 3
    base = n_start;
    req_valid = 1'b1; req_opc = 2'b10; req_a = 4'h7; req_b = 4'h9;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("mid_ctl", 32'({start, sync_rst, busy, rsp_valid}), 0);
    check("mid_ready", 32'(req_ready), 1);
    check("mid_lat", 32'({opc_code, operand_a, operand_b}), 0);
    check("mid_rsp", 32'({rsp_error, rsp_result}), 0);
    step();
    rst = 1'b1;
    step();
    check("mid_nstart", 32'(n_start - base), 1);
    check("mid_norsp", 32'({rsp_valid, req_ready}), 32'b01);
    req_valid = 1'b1; req_opc = 2'b01; req_a = 4'h9; req_b = 4'h0;
    step();
    req_valid = 1'b0;
    check("sq_start", 32'({start, opc_code}), 32'b101);
    step();
    step();
    op_done = 1'b1; result_in = 8'h03;
    step();
    op_done = 1'b0;
    check("sq_rsp", 32'({rsp_valid, rsp_error, rsp_result}), 32'h203);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // no op_done for 20 RUN cycles
    base = n_start;
    req_valid = 1'b1; req_opc = 2'b00; req_a = 4'h4; req_b = 4'h1;
    step();
    req_valid = 1'b0;
    step();
    for (int k = 1; k <= 20; k++) begin
      if (start || rsp_valid) begin
        check("tmo_run", 32'({start, rsp_valid}), 0);
      end
      step();
    end
`ifdef DISPATCH_TIMEOUT_EN
    check("tmo_abort", 32'({start, sync_rst, busy}), 32'b111);
    step();
    check("tmo_rsp", 32'({rsp_valid, rsp_error, sync_rst}), 32'b110);
    check("tmo_res", 32'(rsp_result), 0);
    check("tmo_nstart", 32'(n_start - base), 2);
`else
    repeat (10) step();
    check("tmo_wait", 32'({start, sync_rst, busy, rsp_valid}), 32'b0010);
    op_done = 1'b1; result_in = 8'h44;
    step();
    op_done = 1'b0;
    check("tmo_rsp", 32'({rsp_valid, rsp_error, rsp_result}), 32'h244);
    check("tmo_nstart", 32'(n_start - base), 1);
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // op_done in RUN cycle 20 wins
    base = n_start;
    req_valid = 1'b1; req_opc = 2'b10; req_a = 4'hF; req_b = 4'h7;
    step();
    req_valid = 1'b0;
    step();
    repeat (19) step();
    op_done = 1'b1; result_in = 8'h69;
    step();
    op_done = 1'b0;
    check("c20_rsp", 32'({rsp_valid, rsp_error, rsp_result}), 32'h269);
    check("c20_nstart", 32'(n_start - base), 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("c20_idle", 32'({req_ready, busy}), 32'b10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
